// File: rtl/sc_ir_seq_pkg.sv
// Shared constants for the SPARC-style instruction sequencer: state codes,
// PC-select codes, opcode-field decode values and the instruction-class decoder.
package sc_ir_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXEC      = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_BRANCH = 3'd0,
    CLS_CALL   = 3'd1,
    CLS_ALU    = 3'd2,
    CLS_LD     = 3'd3,
    CLS_ST     = 3'd4,
    CLS_BAD    = 3'd5
  } cls_e;

  localparam logic [1:0] PCSEL_PC4    = 2'b00;
  localparam logic [1:0] PCSEL_DISP22 = 2'b01;
  localparam logic [1:0] PCSEL_DISP30 = 2'b10;

  localparam logic [1:0] OP_FMT2   = 2'b00;
  localparam logic [1:0] OP_CALL   = 2'b01;
  localparam logic [1:0] OP_ALU    = 2'b10;
  localparam logic [1:0] OP_MEM    = 2'b11;
  localparam logic [2:0] OP2_BRANCH = 3'b010;
  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_ST    = 6'b000100;

  function automatic cls_e decode_cls(input logic [1:0] op,
                                      input logic [2:0] op2,
                                      input logic [5:0] op3);
    cls_e c;
    c = CLS_BAD;
    case (op)
      OP_FMT2: if (op2 == OP2_BRANCH) c = CLS_BRANCH; else c = CLS_BAD;
      OP_CALL: c = CLS_CALL;
      OP_ALU:  c = CLS_ALU;
      OP_MEM: begin
        if (op3 == OP3_LD)      c = CLS_LD;
        else if (op3 == OP3_ST) c = CLS_ST;
        else                    c = CLS_BAD;
      end
      default: c = CLS_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sc_ir_seq_wdog.sv
// Memory wait watchdog: counts stalled cycles of one access and flags the
// cycle in which the count would reach the timeout.
module sc_ir_seq_wdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  logic [WW-1:0] r_count;

  // stall counter, restarted at every new access
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) r_count <= '0;
    else if (i_enable)    r_count <= r_count + WW'(1);
    else                  r_count <= r_count;
  end

  // a ready response in the final cycle keeps i_enable low, so it wins
  assign o_expired = i_enable && (r_count == WW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/sc_ir_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/writeback control
// strobes, memory watchdog, sticky trap state and retired-instruction counter.
module sc_ir_sequencer
  import sc_ir_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   SC_IrSeq_CLOCK_50,
  input  logic                   SC_IrSeq_Reset_InHigh,
  input  logic                   SC_IrSeq_Start_InHigh,
  input  logic                   SC_IrSeq_MemReady_InHigh,
  input  logic [1:0]             SC_IrSeq_OP,
  input  logic [2:0]             SC_IrSeq_OP2,
  input  logic [5:0]             SC_IrSeq_OP3,
  input  logic                   SC_IrSeq_CondTrue_InHigh,
  output logic                   SC_IrSeq_MemRead_OutHigh,
  output logic                   SC_IrSeq_MemWrite_OutHigh,
  output logic                   SC_IrSeq_IRWrite_OutHigh,
  output logic                   SC_IrSeq_PCWrite_OutHigh,
  output logic [1:0]             SC_IrSeq_PCSel_Out,
  output logic                   SC_IrSeq_RegWrite_OutHigh,
  output logic [2:0]             SC_IrSeq_State_Out,
  output logic                   SC_IrSeq_Trap_OutHigh,
  output logic [COUNT_WIDTH-1:0] SC_IrSeq_InstrCount_Out
);

  state_e                 r_state;
  state_e                 w_next;
  cls_e                   r_cls;
  cls_e                   w_dec_cls;
  logic [COUNT_WIDTH-1:0] r_instr_count;
  logic                   w_rst;
  logic                   w_ready;
  logic                   w_mem_state;
  logic                   w_expired;
  logic                   w_mem_read;
  logic                   w_mem_write;
  logic                   w_ir_write;
  logic                   w_pc_write;
  logic [1:0]             w_pc_sel;
  logic                   w_reg_write;

  assign w_rst     = SC_IrSeq_Reset_InHigh;
  assign w_ready   = SC_IrSeq_MemReady_InHigh;
  assign w_dec_cls = decode_cls(SC_IrSeq_OP, SC_IrSeq_OP2, SC_IrSeq_OP3);
  assign w_mem_state = (r_state == S_FETCH) ||
                       ((r_state == S_EXEC) && ((r_cls == CLS_LD) || (r_cls == CLS_ST)));

  sc_ir_seq_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .i_clk     (SC_IrSeq_CLOCK_50),
    .i_rst     (w_rst),
    .i_clear   (!w_mem_state || w_ready),
    .i_enable  (w_mem_state && !w_ready),
    .o_expired (w_expired)
  );

  // state, latched instruction class and retired-instruction counter
  always_ff @(posedge SC_IrSeq_CLOCK_50) begin
    if (w_rst) begin
      r_state       <= S_IDLE;
      r_cls         <= CLS_BAD;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      else                     r_cls <= r_cls;
      if (w_pc_write) r_instr_count <= r_instr_count + COUNT_WIDTH'(1);
      else            r_instr_count <= r_instr_count;
    end
  end

  // next-state and strobe decode
  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_sel    = PCSEL_PC4;
    w_reg_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (SC_IrSeq_Start_InHigh) w_next = S_FETCH;
        else                       w_next = S_IDLE;
      end
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = w_ready;
        if (w_ready)        w_next = S_DECODE;
        else if (w_expired) w_next = S_TRAP;
        else                w_next = S_FETCH;
      end
      S_DECODE: begin
        if (w_dec_cls == CLS_BAD) w_next = S_TRAP;
        else                      w_next = S_EXEC;
      end
      S_EXEC: begin
        case (r_cls)
          CLS_BRANCH: begin
            w_pc_write = 1'b1;
            w_pc_sel   = SC_IrSeq_CondTrue_InHigh ? PCSEL_DISP22 : PCSEL_PC4;
            w_next     = S_FETCH;
          end
          CLS_CALL: begin
            w_pc_write  = 1'b1;
            w_pc_sel    = PCSEL_DISP30;
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
          end
          CLS_ALU: w_next = S_WRITEBACK;
          CLS_LD: begin
            w_mem_read = 1'b1;
            if (w_ready)        w_next = S_WRITEBACK;
            else if (w_expired) w_next = S_TRAP;
            else                w_next = S_EXEC;
          end
          CLS_ST: begin
            w_mem_write = 1'b1;
            w_pc_write  = w_ready;
            if (w_ready)        w_next = S_FETCH;
            else if (w_expired) w_next = S_TRAP;
            else                w_next = S_EXEC;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_WRITEBACK: begin
        w_reg_write = 1'b1;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  assign SC_IrSeq_MemRead_OutHigh  = w_mem_read;
  assign SC_IrSeq_MemWrite_OutHigh = w_mem_write;
  assign SC_IrSeq_IRWrite_OutHigh  = w_ir_write;
  assign SC_IrSeq_PCWrite_OutHigh  = w_pc_write;
  assign SC_IrSeq_PCSel_Out        = w_pc_sel;
  assign SC_IrSeq_RegWrite_OutHigh = w_reg_write;
  assign SC_IrSeq_State_Out        = r_state;
  assign SC_IrSeq_Trap_OutHigh     = (r_state == S_TRAP);
  assign SC_IrSeq_InstrCount_Out   = r_instr_count;

endmodule
